// File: rtl/md_unit_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: MD opcodes, scheduler
// state encoding and default latencies.
package md_unit_ctrl_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // Ops that occupy the unit for a multi-cycle latency.
    function automatic logic is_md_start_op(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Purely combinational MD arithmetic: (op, A, B) -> {hi_n, lo_n, div0}.
// Division truncates toward zero; the remainder takes the dividend's sign.
module md_arith
    import md_unit_ctrl_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div0
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic signed [31:0] w_quot_s;
    logic signed [31:0] w_rem_s;
    logic        [31:0] w_quot_u;
    logic        [31:0] w_rem_u;
    logic               w_b_zero;

    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};
    assign w_b_zero = (i_b == 32'd0);

    always_comb begin
        w_quot_s = '0;
        w_rem_s  = '0;
        w_quot_u = '0;
        w_rem_u  = '0;
        if (!w_b_zero) begin
            w_quot_s = $signed(i_a) / $signed(i_b);
            w_rem_s  = $signed(i_a) % $signed(i_b);
            w_quot_u = i_a / i_b;
            w_rem_u  = i_a % i_b;
        end
    end

    always_comb begin
        o_hi   = '0;
        o_lo   = '0;
        o_div0 = 1'b0;
        case (i_op)
            MD_MULT: begin
                o_hi = w_prod_s[63:32];
                o_lo = w_prod_s[31:0];
            end
            MD_MULTU: begin
                o_hi = w_prod_u[63:32];
                o_lo = w_prod_u[31:0];
            end
            MD_DIV: begin
                o_hi   = w_rem_s;
                o_lo   = w_quot_s;
                o_div0 = w_b_zero;
            end
            MD_DIVU: begin
                o_hi   = w_rem_u;
                o_lo   = w_quot_u;
                o_div0 = w_b_zero;
            end
            default: begin
                o_hi   = '0;
                o_lo   = '0;
                o_div0 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide unit with HI/LO registers and the scheduler
// that holds busy/stall until the result is committed.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | HI/LO valid; accepts a start or an mthi/mtlo write
//   ST_BUSY | result buffered, counting down; commit when count hits 1
module md_unit_ctrl
    import md_unit_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op_E,
    input  logic        start_E,
    input  logic [31:0] A_E,
    input  logic [31:0] B_E,
    input  logic        md_D,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] md_rd,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e   r_state;
    md_state_e   w_state_nxt;
    logic [3:0]  r_count;
    logic [31:0] r_hi_n;
    logic [31:0] r_lo_n;
    logic        r_div0;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic        w_div0;
    logic        w_start;
    logic        w_commit;
    logic        w_idle;

    md_arith u_arith (
        .i_op   (md_op_E),
        .i_a    (A_E),
        .i_b    (B_E),
        .o_hi   (w_hi),
        .o_lo   (w_lo),
        .o_div0 (w_div0)
    );

    assign w_idle   = (r_state == ST_IDLE);
    assign w_start  = start_E && is_md_start_op(md_op_E);
    assign w_commit = (r_state == ST_BUSY) && (r_count == 4'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start)  w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_commit) w_state_nxt = ST_IDLE;
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_hi_n  <= '0;
            r_lo_n  <= '0;
            r_div0  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            if (w_idle && w_start) begin
                r_hi_n  <= w_hi;
                r_lo_n  <= w_lo;
                r_div0  <= w_div0;
                r_count <= is_div_op(md_op_E) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            end else if (!w_idle) begin
                r_count <= r_count - 4'd1;
            end

            // A divide by zero still spends the full latency but leaves HI/LO alone.
            if (w_commit) begin
                if (!r_div0) begin
                    r_hi <= r_hi_n;
                    r_lo <= r_lo_n;
                end
            end else if (w_idle && !w_start) begin
                if (md_op_E == MD_MTHI) r_hi <= A_E;
                if (md_op_E == MD_MTLO) r_lo <= A_E;
            end
        end
    end

    assign busy     = (r_state == ST_BUSY);
    assign md_stall = md_D & (start_E | busy);
    assign HI       = r_hi;
    assign LO       = r_lo;

    always_comb begin
        md_rd = '0;
        if (md_op_E == MD_MFHI) md_rd = r_hi;
        else if (md_op_E == MD_MFLO) md_rd = r_lo;
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: expected HI/LO queued at start, checked at commit.
`timescale 1ns/1ps
module tb_md_unit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op_E;
    logic        start_E;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic        md_D;
    logic        busy;
    logic        md_stall;
    logic [31:0] md_rd;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_op_E  (md_op_E),
        .start_E  (start_E),
        .A_E      (A_E),
        .B_E      (B_E),
        .md_D     (md_D),
        .busy     (busy),
        .md_stall (md_stall),
        .md_rd    (md_rd),
        .HI       (HI),
        .LO       (LO)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Issue one MD op, push its expected HI/LO, then follow busy to the commit.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int n_cyc,
                          input logic d, input logic restart);
        int cnt;
        logic [63:0] e;
        md_op_E = op; start_E = 1'b1; A_E = a; B_E = b; md_D = d;
        #1;
        check({tag, "_stall_start"}, {63'd0, md_stall}, {63'd0, d});
        exp_q.push_back({exp_hi, exp_lo});
        tick();
        start_E = 1'b0; md_op_E = 4'd0; A_E = 32'd0; B_E = 32'd0;
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            if (restart && cnt == 2) begin
                md_op_E = 4'd3; start_E = 1'b1; A_E = 32'd100; B_E = 32'd7;
                #1;
            end else begin
                start_E = 1'b0; md_op_E = 4'd0;
                #1;
            end
            if (md_stall !== d) check({tag, "_stall_busy"}, {63'd0, md_stall}, {63'd0, d});
            tick();
        end
        start_E = 1'b0; md_op_E = 4'd0;
        check({tag, "_busy_cycles"}, 64'(cnt), 64'(n_cyc));
        #1;
        check({tag, "_stall_after"}, {63'd0, md_stall}, 64'd0);
        check({tag, "_q_nonempty"}, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_HI"}, {32'd0, HI}, {32'd0, e[63:32]});
            check({tag, "_LO"}, {32'd0, LO}, {32'd0, e[31:0]});
        end
        md_D = 1'b0;
    endtask

    initial begin
        reset = 1'b1; md_op_E = 4'd0; start_E = 1'b0; A_E = '0; B_E = '0; md_D = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_HI", {32'd0, HI}, 64'd0);
        check("rst_LO", {32'd0, LO}, 64'd0);
        check("rst_stall", {63'd0, md_stall}, 64'd0);
        md_D = 1'b1;
        #1;
        check("idle_stall_mdD", {63'd0, md_stall}, 64'd0);
        md_D = 1'b0;
        tick();

        // mult -2 * 3 with md_D held high
        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b1, 1'b0);
        md_op_E = 4'd6;
        #1;
        check("mflo_after_mult", {32'd0, md_rd}, {32'd0, 32'hFFFF_FFFA});
        md_op_E = 4'd0;
        tick();

        // divu 17/5; mfhi while busy must return the committed (old) HI
        md_op_E = 4'd4; start_E = 1'b1; A_E = 32'd17; B_E = 32'd5;
        exp_q.push_back({32'd2, 32'd3});
        tick();
        start_E = 1'b0; md_op_E = 4'd5;
        #1;
        check("mfhi_during_busy", {32'd0, md_rd}, {32'd0, 32'hFFFF_FFFF});
        check("divu_busy", {63'd0, busy}, 64'd1);
        md_op_E = 4'd0;
        for (int i = 0; i < 9; i++) tick();
        check("divu_busy_last", {63'd0, busy}, 64'd1);
        tick();
        check("divu_busy_drop", {63'd0, busy}, 64'd0);
        begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("divu_HI", {32'd0, HI}, {32'd0, e[63:32]});
            check("divu_LO", {32'd0, LO}, {32'd0, e[31:0]});
        end
        tick();

        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0, 1'b0);
        tick();

        // multu with a stray start mid-flight; md_D low so no stall
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 1'b0, 1'b1);
        tick();

        md_op_E = 4'd7; A_E = 32'h1234;
        tick();
        md_op_E = 4'd8; A_E = 32'h5678;
        tick();
        md_op_E = 4'd0; A_E = 32'd0;
        check("mthi", {32'd0, HI}, 64'h1234);
        check("mtlo", {32'd0, LO}, 64'h5678);
        run_op("div0", 4'd3, 32'd99, 32'd0, 32'h1234, 32'h5678, 10, 1'b1, 1'b0);
        tick();

        // reset at busy cycle 3 of a div
        md_op_E = 4'd3; start_E = 1'b1; A_E = 32'd50; B_E = 32'd7;
        tick();
        start_E = 1'b0; md_op_E = 4'd0;
        tick(); tick();
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_HI", {32'd0, HI}, 64'd0);
        check("midrst_LO", {32'd0, LO}, 64'd0);
        for (int i = 0; i < 15; i++) begin
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
                check("no_late_commit", {HI, LO}, 64'd0);
            tick();
        end
        check("post_rst_HI", {32'd0, HI}, 64'd0);
        check("post_rst_LO", {32'd0, LO}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Multi-cycle multiply/divide unit with its scheduler, beside the Execute-stage ALU.
- Accepts one MD operation per start pulse, using the already-forwarded E-stage operands.
- Counts out a fixed latency, then commits the result to the HI/LO registers.
- Drives busy/stall so that the hazard logic freezes D-stage MD-class instructions until HI/LO is valid.

Parameters:
- MULT_CYCLES, 5, cycles busy is held for mult/multu (range 1..15).
- DIV_CYCLES, 10, cycles busy is held for div/divu (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- md_op_E  input  4  E-stage MD opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; others = none.
- start_E  input  1  qualifies md_op_E 1..4 this cycle.
- A_E  input  32  rs operand, post-forwarding.
- B_E  input  32  rt operand, post-forwarding.
- md_D  input  1  D-stage instruction is MD-class (ops 1..8).
- busy  output  1  an operation is in flight.
- md_stall  output  1  stall request to the D stage.
- md_rd  output  32  read data for mfhi/mflo.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (synchronous, on the clk edge while reset=1):
  - state=IDLE, count=0, busy=0.
  - HI=0, LO=0, internal result buffers=0.
  - md_stall follows its combinational equation (0 if md_D=0).
  - A reset during BUSY abandons the operation; HI/LO still become 0.
  - reset has priority over every other event.
- States: IDLE, BUSY.
- IDLE -> BUSY on an edge with start_E=1 and md_op_E in 1..4. At that edge:
  - compute the result into the internal buffers hi_n/lo_n.
  - load count with MULT_CYCLES or DIV_CYCLES.
- BUSY:
  - count decrements each edge.
  - On the edge where count==1: write hi_n/lo_n into HI/LO and go to IDLE.
- busy = (state==BUSY), registered.
- Timing: start in cycle T -> busy=1 in cycles T+1..T+N; new HI/LO visible and busy=0 in cycle T+N+1.
- Arithmetic:
  - mult: signed 32x32 -> 64-bit product; HI = upper half, LO = lower half.
  - multu: same, unsigned.
  - div: signed; LO = quotient, HI = remainder; truncation toward zero, remainder takes the sign of the dividend.
  - divu: unsigned; LO = quotient, HI = remainder.
- Divide by zero: HI/LO are left unchanged at commit, but busy still runs the full DIV_CYCLES.
- mthi/mtlo:
  - Write A_E into HI/LO on the edge, only in IDLE with no start that edge.
  - If issued while BUSY they are ignored; the stall makes this unreachable legally.
- mfhi/mflo: md_rd is combinational, HI for op 5, LO for op 6, else 0. It returns committed values only, never the in-flight buffers.
- Start while BUSY: ignored; no restart, no counter reload.
- md_stall = md_D & (start_E | busy), combinational. This covers the back-to-back case where the MD op is in E and the next one is in D.
- Simultaneous commit edge with mthi/mtlo: impossible because the op is gated by IDLE; the commit wins.

Decomposition:
- Shared package/header: MD opcode constants (MD_NONE..MD_MTLO, 4 bits), IDLE/BUSY state encodings, default latencies.
- Natural sub-module: md_arith, purely combinational; (op, A, B) -> {hi_n, lo_n, div0}. Keeps the arithmetic separable from the sequencing FSM.

Test Plan:
- mult sign:
  - Stimulus: reset, then start mult with A=0xFFFFFFFE (-2), B=3.
  - Required: busy high for 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA; md_rd for mflo = 0xFFFFFFFA.
- divu:
  - Stimulus: start divu with A=17, B=5.
  - Required: busy for 10 cycles; afterwards LO=3, HI=2. mfhi during busy returns the old HI.
- div signed:
  - Stimulus: start div with A=-7, B=2.
  - Required: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- Divide by zero:
  - Stimulus: mthi 0x1234, mtlo 0x5678, then div by zero.
  - Required: busy for 10 cycles; HI=0x1234 and LO=0x5678 unchanged.
- Stall:
  - Stimulus: start mult with md_D=1 in the same cycle, md_D held high.
  - Required: md_stall=1 from that cycle through the last busy cycle, 0 the cycle busy drops. With md_D=0, md_stall=0 throughout.
- Reset mid-operation:
  - Stimulus: reset at busy cycle 3 of a div.
  - Required: next cycle busy=0, HI=LO=0, and no later commit occurs.
